muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_pkg.sv | 30 +++
 rtl/muldiv_sign_adjust.sv | 15 +
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared control-code header: ALU and multiply/divide operation codes plus default bus widths.
// The mul/div codes sit in the upper half of the code space so the two units can share one code bus.
package muldiv_unit_pkg;

  localparam int DEF_IO_BUS_WIDTH  = 32;
  localparam int DEF_CTR_BUS_WIDTH = 4;

  typedef enum logic [DEF_CTR_BUS_WIDTH-1:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_XOR = 4'h4,
    ALU_NOR = 4'h5,
    ALU_SLT = 4'h6,
    ALU_SLL = 4'h7
  } alu_code_e;

  typedef enum logic [DEF_CTR_BUS_WIDTH-1:0] {
    MD_MULT  = 4'h8,
    MD_MULTU = 4'h9,
    MD_DIV   = 4'hA,
    MD_DIVU  = 4'hB,
    MD_MFHI  = 4'hC,
    MD_MFLO  = 4'hD,
    MD_MTHI  = 4'hE,
    MD_MTLO  = 4'hF
  } md_code_e;

endpackage

// File: rtl/muldiv_sign_adjust.sv
// Conditional two's-complement negation: turns signed operands into magnitudes
// and applies the final sign to products, quotients and remainders.
module muldiv_sign_adjust
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = DEF_IO_BUS_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers, one result bit per cycle.
// Results are presented combinationally during DONE and committed to HI/LO when DONE ends.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int IO_BUS_WIDTH  = DEF_IO_BUS_WIDTH,
  parameter int CTR_BUS_WIDTH = DEF_CTR_BUS_WIDTH
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic [CTR_BUS_WIDTH-1:0] i_ctr_code,
  input  logic [IO_BUS_WIDTH-1:0]  i_data_a,
  input  logic [IO_BUS_WIDTH-1:0]  i_data_b,
  output logic [IO_BUS_WIDTH-1:0]  o_data,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_div_zero
);

  localparam int W     = IO_BUS_WIDTH;
  localparam int CNT_W = $clog2(W) + 1;

  // state | meaning
  // IDLE  | waiting for i_start; MTHI/MTLO writes, MFHI/MFLO reads
  // MUL   | shift-add, one multiplier bit per cycle
  // DIV   | restoring divide, one quotient bit per cycle
  // DONE  | result visible on HI/LO, o_done pulse
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e state, state_nxt;

  logic is_mult, is_multu, is_div, is_divu, is_mfhi, is_mflo, is_mthi, is_mtlo;
  always_comb begin
    is_mult  = (i_ctr_code == CTR_BUS_WIDTH'(MD_MULT));
    is_multu = (i_ctr_code == CTR_BUS_WIDTH'(MD_MULTU));
    is_div   = (i_ctr_code == CTR_BUS_WIDTH'(MD_DIV));
    is_divu  = (i_ctr_code == CTR_BUS_WIDTH'(MD_DIVU));
    is_mfhi  = (i_ctr_code == CTR_BUS_WIDTH'(MD_MFHI));
    is_mflo  = (i_ctr_code == CTR_BUS_WIDTH'(MD_MFLO));
    is_mthi  = (i_ctr_code == CTR_BUS_WIDTH'(MD_MTHI));
    is_mtlo  = (i_ctr_code == CTR_BUS_WIDTH'(MD_MTLO));
  end

  logic idle_start, accept_mul, accept_div, op_signed, a_neg, b_neg;
  assign idle_start = (state == S_IDLE) && i_start;
  assign accept_mul = idle_start && (is_mult || is_multu);
  assign accept_div = idle_start && (is_div || is_divu);
  assign op_signed  = is_mult || is_div;
  assign a_neg      = op_signed && i_data_a[W-1];
  assign b_neg      = op_signed && i_data_b[W-1];

  logic [2*W-1:0]   acc;
  logic [W-1:0]     op_q, hi_q, lo_q;
  logic [CNT_W-1:0] cnt;
  logic             div_q, neg_res, neg_rem, div_zero_q;

  logic [W-1:0] a_mag, b_mag;
  muldiv_sign_adjust #(.WIDTH(W)) u_a_mag (.value(i_data_a), .negate(a_neg), .result(a_mag));
  muldiv_sign_adjust #(.WIDTH(W)) u_b_mag (.value(i_data_b), .negate(b_neg), .result(b_mag));

  logic last, dz;
  assign last = (cnt == '0);
  assign dz   = div_q && (op_q == '0);

  logic [W:0]     add_sum, sub_diff;
  logic [2*W-1:0] mul_step, div_step;
  always_comb begin
    add_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, op_q};
    sub_diff = acc[2*W-1:W-1] - {1'b0, op_q};
    mul_step = acc[0] ? {add_sum, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};
    // sub_diff[W] is the borrow: partial remainder smaller than divisor, so restore
    div_step = sub_diff[W] ? {acc[2*W-2:0], 1'b0}
                           : {sub_diff[W-1:0], acc[W-2:0], 1'b1};
  end

  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot_fix, rem_fix, rem_src;
  assign rem_src = dz ? acc[W-1:0] : acc[2*W-1:W];
  muldiv_sign_adjust #(.WIDTH(2*W)) u_prod_fix (.value(acc), .negate(neg_res), .result(prod_fix));
  muldiv_sign_adjust #(.WIDTH(W)) u_quot_fix (.value(acc[W-1:0]), .negate(neg_res), .result(quot_fix));
  muldiv_sign_adjust #(.WIDTH(W)) u_rem_fix (.value(rem_src), .negate(neg_rem), .result(rem_fix));

  logic [W-1:0] res_hi, res_lo, hi_view, lo_view;
  always_comb begin
    res_hi  = div_q ? rem_fix : prod_fix[2*W-1:W];
    res_lo  = div_q ? (dz ? '1 : quot_fix) : prod_fix[W-1:0];
    hi_view = (state == S_DONE) ? res_hi : hi_q;
    lo_view = (state == S_DONE) ? res_lo : lo_q;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept_mul)      state_nxt = S_MUL;
        else if (accept_div) state_nxt = S_DIV;
      end
      S_MUL:   if (last)       state_nxt = S_DONE;
      S_DIV:   if (dz || last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      acc        <= '0;
      op_q       <= '0;
      cnt        <= '0;
      div_q      <= 1'b0;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept_mul || accept_div) begin
            acc     <= {{W{1'b0}}, (accept_mul ? b_mag : a_mag)};
            op_q    <= accept_mul ? a_mag : b_mag;
            cnt     <= CNT_W'(W - 1);
            div_q   <= accept_div;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            if (i_data_b != '0) div_zero_q <= 1'b0;
            else if (accept_div) div_zero_q <= 1'b1;
          end
          if (idle_start && is_mthi) hi_q <= i_data_a;
          if (idle_start && is_mtlo) lo_q <= i_data_a;
        end
        S_MUL: begin
          acc <= mul_step;
          if (!last) cnt <= cnt - CNT_W'(1);
        end
        S_DIV: begin
          if (dz) begin
            cnt <= '0;
          end else begin
            acc <= div_step;
            if (!last) cnt <= cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_data = '0;
    if (is_mfhi)      o_data = hi_view;
    else if (is_mflo) o_data = lo_view;
  end

  assign o_busy     = (state == S_MUL) || (state == S_DIV);
  assign o_done     = (state == S_DONE);
  assign o_div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a cycle-timeline arithmetic model checked every cycle,
// plus directed operations with hand-computed HI/LO, latency and flag expectations.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  code = 4'hC;
  logic [31:0] da = '0;
  logic [31:0] db = '0;
  logic [31:0] o_data;
  logic        o_busy, o_done, o_div_zero;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.IO_BUS_WIDTH(32), .CTR_BUS_WIDTH(4)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_start    (start),
    .i_ctr_code (code),
    .i_data_a   (da),
    .i_data_b   (db),
    .o_data     (o_data),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_div_zero (o_div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_arith(input logic [3:0] c);
    return (c == MD_MULT) || (c == MD_MULTU) || (c == MD_DIV) || (c == MD_DIVU);
  endfunction

  // Reference arithmetic written directly from the operation definitions
  function automatic void model_result(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                       output logic [31:0] hi, output logic [31:0] lo);
    logic [63:0] p;
    int sa, sb;
    sa = a;
    sb = b;
    hi = '0;
    lo = '0;
    if (c == MD_MULT) begin
      p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      {hi, lo} = p;
    end else if (c == MD_MULTU) begin
      p = {32'b0, a} * {32'b0, b};
      {hi, lo} = p;
    end else if (b == 0) begin
      lo = 32'hFFFF_FFFF;
      hi = a;
    end else if (c == MD_DIV) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        lo = 32'h8000_0000;
        hi = 32'h0;
      end else begin
        lo = sa / sb;
        hi = sa % sb;
      end
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endfunction

  // Timeline model: m_left counts busy cycles, m_done marks the completion cycle
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          m_left = 0;
  bit          m_done = 1'b0;
  bit          m_dz = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0; m_dz = 1'b0;
    end else if (m_done) begin
      m_hi = p_hi; m_lo = p_lo; m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_done = 1'b1;
    end else if (start) begin
      if (is_arith(code)) begin
        model_result(code, da, db, p_hi, p_lo);
        m_left = ((code == MD_DIV || code == MD_DIVU) && db == 0) ? 1 : 32;
        if (db != 0) m_dz = 1'b0;
        else if (code == MD_DIV || code == MD_DIVU) m_dz = 1'b1;
      end else if (code == MD_MTHI) begin
        m_hi = da;
      end else if (code == MD_MTLO) begin
        m_lo = da;
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] exp_data;
    exp_data = '0;
    if (!rst) begin
      if (code == MD_MFHI)      exp_data = m_done ? p_hi : m_hi;
      else if (code == MD_MFLO) exp_data = m_done ? p_lo : m_lo;
    end
    check("cyc_busy", 32'(o_busy), 32'(m_left > 0));
    check("cyc_done", 32'(o_done), 32'(m_done));
    check("cyc_div_zero", 32'(o_div_zero), 32'(m_dz));
    check("cyc_data", o_data, exp_data);
  end

  // Issue one operation at posedge+1; optionally inject an ignored DIV 9/3 start at cycle inj
  task automatic run_op(input string name, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e_hi, input logic [31:0] e_lo, input int e_lat,
                        input logic e_dz, input int inj);
    int lat, ndone;
    logic [31:0] d_hi;
    lat = -1; ndone = 0; d_hi = '0;
    start = 1'b1; code = c; da = a; db = b;
    @(posedge clk); #1;
    start = 1'b0; code = MD_MFHI;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      if (cyc == inj) begin
        start = 1'b1; code = MD_DIV; da = 32'd9; db = 32'd3;
      end
      @(negedge clk);
      if (o_done) begin
        ndone++;
        if (lat < 0) begin
          lat = cyc;
          d_hi = o_data;
        end
      end
      @(posedge clk); #1;
      start = 1'b0; code = MD_MFHI;
    end
    check({name, " latency"}, 32'(lat), 32'(e_lat));
    check({name, " done_pulses"}, 32'(ndone), 32'd1);
    check({name, " hi_in_done"}, d_hi, e_hi);
    check({name, " hi"}, o_data, e_hi);
    code = MD_MFLO; #1;
    check({name, " lo"}, o_data, e_lo);
    check({name, " div_zero"}, 32'(o_div_zero), 32'(e_dz));
  endtask

  initial begin
    int nd;
    @(negedge clk);
    check("rst data", o_data, 32'h0);
    check("rst busy", 32'(o_busy), 32'h0);
    check("rst done", 32'(o_done), 32'h0);
    check("rst div_zero", 32'(o_div_zero), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op("mult -3*7",    MD_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 1'b0, 0);
    run_op("multu max^2",  MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 1'b0, 0);
    run_op("mult -2*-3",   MD_MULT,  32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0,         32'd6,         33, 1'b0, 0);
    run_op("mult min*-1",  MD_MULT,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 33, 1'b0, 0);
    run_op("div -7/2",     MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0, 0);
    run_op("divu 7/2",     MD_DIVU,  32'd7,         32'd2,        32'd1,         32'd3,         33, 1'b0, 0);
    run_op("divu 7/0",     MD_DIVU,  32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF, 2,  1'b1, 0);
    run_op("divu 8/2",     MD_DIVU,  32'd8,         32'd2,        32'd0,         32'd4,         33, 1'b0, 0);
    run_op("div min/-1",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 33, 1'b0, 0);
    run_op("div -5/0",     MD_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 2,  1'b1, 0);
    run_op("mult 5*5 inj", MD_MULT,  32'd5,         32'd5,        32'd0,         32'd25,        33, 1'b0, 10);
    run_op("divu 100/7",   MD_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        33, 1'b0, 0);
    run_op("div 7/-2",     MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33, 1'b0, 0);

    // undefined code with start: nothing moves
    @(posedge clk); #1;
    start = 1'b1; code = ALU_OR; da = 32'hDEAD_BEEF; db = 32'h5;
    @(posedge clk); #1;
    start = 1'b0; code = MD_MFHI;
    @(negedge clk);
    check("undef busy", 32'(o_busy), 32'h0);
    check("undef hi", o_data, 32'd1);

    // MTLO then MTHI, reads back without a done pulse
    @(posedge clk); #1;
    start = 1'b1; code = MD_MTLO; da = 32'h0000_ABCD;
    @(posedge clk); #1;
    code = MD_MTHI; da = 32'h0000_1234;
    @(posedge clk); #1;
    start = 1'b0; code = MD_MFHI;
    @(negedge clk);
    check("mthi read", o_data, 32'h0000_1234);
    check("mthi no_done", 32'(o_done), 32'h0);
    @(posedge clk); #1;
    code = MD_MFLO; #1;
    check("mtlo read", o_data, 32'h0000_ABCD);

    // reset at cycle 5 of a MULT aborts it
    start = 1'b1; code = MD_MULT; da = 32'd5; db = 32'd6;
    @(posedge clk); #1;
    start = 1'b0; code = MD_MFHI;
    repeat (4) @(posedge clk);
    #1;
    check("pre-reset busy", 32'(o_busy), 32'h1);
    rst = 1'b1; #1;
    check("abort busy", 32'(o_busy), 32'h0);
    check("abort hi", o_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    nd = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (o_done) nd++;
    end
    check("abort no_done", 32'(nd), 32'h0);
    @(posedge clk); #1;
    check("abort mfhi", o_data, 32'h0);
    code = MD_MFLO; #1;
    check("abort mflo", o_data, 32'h0);

    run_op("multu 3*4 post-reset", MD_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 33, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
